// File: rtl/lsp_wegt_pkg.sv
// Shared constants, FSM state type and ETSI-style saturating arithmetic
// helpers for the LSP weighting-coefficient generator.
package lsp_wegt_pkg;

  localparam logic signed [15:0] PI04    = 16'sd1029;
  localparam logic signed [15:0] PI92    = 16'sd23677;
  localparam logic signed [15:0] CONST10 = 16'sd20480;
  localparam logic signed [15:0] CONST12 = 16'sd19661;
  localparam logic signed [15:0] OFFS    = 16'sd8192;
  localparam logic signed [15:0] BASE    = 16'sd2048;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIFF,
    ST_WEIGHT,
    ST_EMPH,
    ST_MAX,
    ST_NORM,
    ST_OUT
  } wegt_state_e;

  function automatic logic signed [15:0] add_sat16(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s > 17'sd32767) return 16'sh7fff;
    if (s < -17'sd32768) return 16'sh8000;
    return s[15:0];
  endfunction

  function automatic logic signed [15:0] sub_sat16(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
    logic signed [16:0] s;
    s = {a[15], a} - {b[15], b};
    if (s > 17'sd32767) return 16'sh7fff;
    if (s < -17'sd32768) return 16'sh8000;
    return s[15:0];
  endfunction

  // 2ab; only (-32768)^2 overflows the doubled product.
  function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [31:0] p;
    if (a == 16'sh8000 && b == 16'sh8000) return 32'sh7fffffff;
    p = {{16{a[15]}}, a} * {{16{b[15]}}, b};
    return {p[30:0], 1'b0};
  endfunction

  function automatic logic signed [31:0] l_shl_sat32(input logic signed [31:0] x,
                                                     input logic [4:0] n);
    logic signed [63:0] e;
    e = {{32{x[31]}}, x};
    e = e <<< n;
    if (e > 64'sd2147483647) return 32'sh7fffffff;
    if (e < -64'sd2147483648) return 32'sh80000000;
    return e[31:0];
  endfunction

  function automatic logic signed [15:0] shl_sat16(input logic signed [15:0] x,
                                                   input logic [3:0] n);
    logic signed [31:0] e;
    e = {{16{x[15]}}, x};
    e = e <<< n;
    if (e > 32'sd32767) return 16'sh7fff;
    if (e < -32'sd32768) return 16'sh8000;
    return e[15:0];
  endfunction

  function automatic logic signed [15:0] hi16(input logic signed [31:0] x);
    return x[31:16];
  endfunction

endpackage

// File: rtl/lsp_weight_gen_if.sv
// LSP input stream and weight output stream of the generator.
// master: LSP buffer / codebook search side; slave: the generator.
interface lsp_weight_gen_if;
  logic        lsp_valid;
  logic        lsp_ready;
  logic [15:0] lsp_data;
  logic        wegt_valid;
  logic        wegt_ready;
  logic [15:0] wegt_data;
  logic        wegt_last;

  modport master (output lsp_valid, lsp_data, wegt_ready,
                  input  lsp_ready, wegt_valid, wegt_data, wegt_last);
  modport slave  (input  lsp_valid, lsp_data, wegt_ready,
                  output lsp_ready, wegt_valid, wegt_data, wegt_last);
endinterface

// File: rtl/lsp_wegt_norm_s.sv
// Leading-sign count of a 16-bit signed value (norm_s); norm_s(0) = 0.
module lsp_wegt_norm_s (
  input  logic signed [15:0] x_i,
  output logic [3:0]         sft_o
);
  logic [14:0] mag;
  logic        found;

  // count redundant sign bits below bit 15
  always_comb begin
    mag   = x_i[15] ? ~x_i[14:0] : x_i[14:0];
    sft_o = 4'd0;
    found = 1'b0;
    for (int b = 14; b >= 0; b--) begin
      if (!found) begin
        if (mag[b]) found = 1'b1;
        else        sft_o = sft_o + 4'd1;
      end
    end
    if (x_i == 16'sd0) sft_o = 4'd0;
  end
endmodule

// File: rtl/lsp_weight_gen.sv
// LSP weighting-coefficient generator (Get_wegt, order M).
// Optional build macro LSP_WEGT_NORM_EN: adds MAX/NORM passes and
// normalises the streamed weights; otherwise raw weights, sft_out = 0.
//
// state  | meaning
// IDLE   | waiting for flsp[0]
// LOAD   | collecting flsp[1..M-1]
// DIFF   | buf[i] from neighbouring LSPs, one index per cycle
// WEIGHT | buf[i] -> w[i]
// EMPH   | CONST12 scaling of w[EMPH_LO] and w[EMPH_HI]
// MAX    | running max of w[]
// NORM   | shift = norm_s(max)
// OUT    | stream w[i] << shift with backpressure
module lsp_weight_gen
  import lsp_wegt_pkg::*;
#(
  parameter int M       = 10,
  parameter int EMPH_LO = 4,
  parameter int EMPH_HI = 5
) (
  input  logic             clk,
  input  logic             reset,
  lsp_weight_gen_if.slave  bus,
  output logic [3:0]       sft_out,
  output logic             busy
);
  localparam int IW = $clog2(M);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);
  localparam logic [CW-1:0] CNT_M    = CW'(M);
  localparam bit TWO_EMPH = (EMPH_LO != EMPH_HI);

  wegt_state_e        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx, idx_p1, idx_m1, eidx;
  logic               armed_q;
  logic               lsp_fire, wegt_fire;
  logic signed [15:0] flsp_q [M];
  logic signed [15:0] work_q [M];
  logic signed [15:0] diff_v, out_w;

`ifdef LSP_WEGT_NORM_EN
  logic signed [15:0] max_q;
  logic [3:0]         sft_q, norm_sft;

  lsp_wegt_norm_s u_norm (.x_i(max_q), .sft_o(norm_sft));
`endif

  function automatic logic signed [15:0] calc_w(input logic signed [15:0] b);
    logic signed [15:0] t;
    if (b > 16'sd0) return BASE;
    t = hi16(l_shl_sat32(l_mult(b, b), 5'd2));
    t = hi16(l_shl_sat32(l_mult(t, CONST10), 5'd2));
    return add_sat16(t, BASE);
  endfunction

  function automatic logic signed [15:0] calc_emph(input logic signed [15:0] w);
    return hi16(l_shl_sat32(l_mult(w, CONST12), 5'd1));
  endfunction

  assign idx    = cnt_q[IW-1:0];
  assign idx_p1 = idx + IW'(1);
  assign idx_m1 = idx - IW'(1);
  assign eidx   = (cnt_q == '0) ? IW'(EMPH_LO) : IW'(EMPH_HI);

  assign bus.lsp_ready = armed_q &&
                         ((state_q == ST_IDLE) || (state_q == ST_LOAD && cnt_q != CNT_M));
  assign lsp_fire      = bus.lsp_valid && bus.lsp_ready;
  assign bus.wegt_valid = (state_q == ST_OUT);
  assign bus.wegt_last  = bus.wegt_valid && (cnt_q == CNT_LAST);
  assign wegt_fire      = bus.wegt_valid && bus.wegt_ready;
  assign busy           = (state_q != ST_IDLE);

`ifdef LSP_WEGT_NORM_EN
  assign out_w   = shl_sat16(work_q[idx], sft_q);
  assign sft_out = sft_q;
`else
  assign out_w   = work_q[idx];
  assign sft_out = 4'd0;
`endif
  assign bus.wegt_data = bus.wegt_valid ? out_w : '0;

  // lsp_ready stays low for the first cycle after reset
  always_ff @(posedge clk) begin
    if (reset) armed_q <= 1'b0;
    else       armed_q <= 1'b1;
  end

  // state and index register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and index sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (lsp_fire) begin
        state_d = ST_LOAD;
        cnt_d   = CW'(1);
      end
      ST_LOAD: begin
        if (cnt_q == CNT_M) begin
          state_d = ST_DIFF;
          cnt_d   = '0;
        end else if (lsp_fire) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DIFF: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_WEIGHT;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_WEIGHT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_EMPH;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_EMPH: begin
        if (TWO_EMPH && cnt_q == '0) begin
          cnt_d = CW'(1);
        end else begin
          cnt_d = '0;
`ifdef LSP_WEGT_NORM_EN
          state_d = ST_MAX;
`else
          state_d = ST_OUT;
`endif
        end
      end
      ST_MAX: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_NORM;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      ST_NORM: begin
        state_d = ST_OUT;
        cnt_d   = '0;
      end
      ST_OUT: if (wegt_fire) begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // neighbour difference for the current DIFF index; ends use fixed guards
  always_comb begin
    diff_v = '0;
    if (idx == '0)
      diff_v = sub_sat16(flsp_q[1], PI04 + OFFS);
    else if (cnt_q == CNT_LAST)
      diff_v = sub_sat16(PI92 - OFFS, flsp_q[M-2]);
    else
      diff_v = sub_sat16(sub_sat16(flsp_q[idx_p1], flsp_q[idx_m1]), OFFS);
  end

  // datapath: load, buf -> w in place, emphasis, max and shift capture
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < M; i++) begin
        flsp_q[i] <= '0;
        work_q[i] <= '0;
      end
`ifdef LSP_WEGT_NORM_EN
      max_q <= '0;
      sft_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: if (lsp_fire) flsp_q[idx] <= $signed(bus.lsp_data);
        ST_DIFF: begin
          work_q[idx] <= diff_v;
`ifdef LSP_WEGT_NORM_EN
          max_q <= '0;
`endif
        end
        ST_WEIGHT: work_q[idx]  <= calc_w(work_q[idx]);
        ST_EMPH:   work_q[eidx] <= calc_emph(work_q[eidx]);
`ifdef LSP_WEGT_NORM_EN
        ST_MAX:  if (work_q[idx] > max_q) max_q <= work_q[idx];
        ST_NORM: sft_q <= norm_sft;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsp_weight_gen.sv
// Directed-vector bench for lsp_weight_gen (M=4, emphasis on w[1], w[2]).
// Expected weights were worked out by hand from the Get_wegt arithmetic;
// the driver queues them and the negedge monitor checks every presented word.
module tb_lsp_weight_gen;
  localparam int M     = 4;
  localparam int NEMPH = 2;
`ifdef LSP_WEGT_NORM_EN
  localparam int LAT  = 3*M + NEMPH + 2;
  localparam bit NORM = 1'b1;
`else
  localparam int LAT  = 2*M + NEMPH + 1;
  localparam bit NORM = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sft_out;
  logic       busy;

  lsp_weight_gen_if bus();

  lsp_weight_gen #(.M(M), .EMPH_LO(1), .EMPH_HI(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .sft_out(sft_out), .busy(busy)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [3:0]  sft;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, acc_cyc = 0, hs_cnt = 0, bp_ph = 0;
  bit   lat_armed = 0, bp_mode = 0, chk_busy_drop = 0;

  // v0: all buf > 0.  v1: buf = -8192 and buf = 0 cases.
  // v2: saturating subtract feeds buf = -32768 -> w = 32767.
  // v3: max 10048 -> norm_s = 1.  (norm_s(2457) = 3 for v0.)
  int vin [4][4] = '{'{1000, 10000, 12000, 20000},
                     '{0, 1029, 15485, 1029},
                     '{0, -32768, 0, 0},
                     '{0, 4101, 20000, 20000}};
  int raw [4][4] = '{'{2048, 2457, 2457, 2048},
                     '{22528, 2457, 27033, 2048},
                     '{32767, 27033, 2457, 2048},
                     '{10048, 2457, 2457, 8268}};
  int nrm [4][4] = '{'{16384, 19656, 19656, 16384},
                     '{22528, 2457, 27033, 2048},
                     '{32767, 27033, 2457, 2048},
                     '{20096, 4914, 4914, 16536}};
  int sft [4]    = '{3, 0, 0, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: drives wegt_ready, then checks the presented word against the queue head
  always @(negedge clk) begin
    if (bp_mode) begin
      bus.wegt_ready = (bp_ph % 4 == 0) || (bp_ph % 4 == 3);
      if (bus.wegt_valid) bp_ph++;
    end else begin
      bus.wegt_ready = 1'b1;
    end
    if (chk_busy_drop) begin
      chk("busy_after_last", int'(busy), 0);
      chk_busy_drop = 0;
    end
    if (bus.wegt_valid) begin
      if (lat_armed) begin
        chk("latency", cyc - acc_cyc, LAT);
        lat_armed = 0;
      end
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got wegt_data %0d, expected no output", bus.wegt_data);
      end else begin
        chk("wegt_data", int'(bus.wegt_data), int'(sb[0].data));
        chk("wegt_last", int'(bus.wegt_last), int'(sb[0].last));
        chk("sft_out",   int'(sft_out),       int'(sb[0].sft));
        chk("busy_in_out", int'(busy), 1);
        if (bus.wegt_ready) begin
          if (bus.wegt_last) chk_busy_drop = 1;
          void'(sb.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  task automatic put(input int w);
    int g = 0;
    bus.lsp_valid = 1'b1;
    bus.lsp_data  = 16'(w);
    while (!bus.lsp_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.lsp_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL lsp_ready_timeout: got lsp_ready 0, expected 1 within 100 cycles");
    end
    acc_cyc = cyc + 1;
    @(negedge clk);
    bus.lsp_valid = 1'b0;
  endtask

  task automatic send(input int v, input bit score, input bit gaps);
    exp_t e;
    if (score) begin
      for (int i = 0; i < M; i++) begin
        e.data = NORM ? 16'(nrm[v][i]) : 16'(raw[v][i]);
        e.last = (i == M - 1);
        e.sft  = NORM ? 4'(sft[v]) : 4'd0;
        sb.push_back(e);
      end
    end
    hs_cnt = 0;
    for (int i = 0; i < M; i++) begin
      put(vin[v][i]);
      if (gaps && i == 1) @(negedge clk);
    end
    if (score) lat_armed = 1;
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || busy) && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
      sb.delete();
    end
    chk("handshakes", hs_cnt, M);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},       int'(busy), 0);
    chk({tag, "_lsp_ready"},  int'(bus.lsp_ready), 0);
    chk({tag, "_wegt_valid"}, int'(bus.wegt_valid), 0);
    chk({tag, "_wegt_data"},  int'(bus.wegt_data), 0);
    chk({tag, "_wegt_last"},  int'(bus.wegt_last), 0);
    chk({tag, "_sft_out"},    int'(sft_out), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish (%0d applied, %0d miscompares)", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    bus.lsp_valid  = 1'b0;
    bus.lsp_data   = '0;
    bus.wegt_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("lsp_ready_after_reset", int'(bus.lsp_ready), 1);

    send(0, 1, 0); drain();
    send(1, 1, 1); drain();
    send(2, 1, 0); drain();

    bp_mode = 1; bp_ph = 0;
    send(3, 1, 0); drain();
    bp_mode = 0;

    // abort in the middle of WEIGHT, then a clean vector
    send(0, 0, 0);
    while (cyc < acc_cyc + 6) @(negedge clk);
    chk("busy_before_abort", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk_idle_outputs("abort");
    reset = 1'b0;
    @(negedge clk);
    chk("lsp_ready_after_abort", int'(bus.lsp_ready), 1);
    send(0, 1, 0); drain();

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
